// File: rtl/dottori_pkg.sv
// Shared types and constants for the dottori ioctl arbiter slice.
package dottori_pkg;

    typedef enum logic [2:0] {
        IDLE,
        NV_REQ,
        NV_WR,
        NV_RD,
        NV_RDV
    } nv_state_e;

    localparam logic [7:0] ROM_INDEX_DEF = 8'd0;
    localparam logic [7:0] NV_INDEX_DEF  = 8'd4;
    localparam int         ROM_AW        = 14;

endpackage

// File: rtl/dottori_reset_hold.sv
// Down-counter that keeps the game in reset for HOLD cycles after reset
// release or after a ROM download ends.
module dottori_reset_hold #(
    parameter int HOLD = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic load_i,
    output logic done_o
);

    localparam int CW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = CW'(HOLD);
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            cnt_q <= CW'(HOLD);
        else
            cnt_q <= cnt_d;
    end

    // Gated by load so the game drops into reset the same cycle a ROM download starts.
    assign done_o = (cnt_q == '0) && !load_i;

endmodule

// File: rtl/dottori_ioctl_arbiter.sv
// Glue between MiSTer ioctl and the dottori core: ROM download routing,
// NVRAM access to the shared work RAM, and game reset sequencing.
module dottori_ioctl_arbiter
    import dottori_pkg::*;
#(
    parameter logic [7:0] ROM_INDEX  = ROM_INDEX_DEF,
    parameter logic [7:0] NV_INDEX   = NV_INDEX_DEF,
    parameter int         RAM_AW     = 11,
    parameter int         RESET_HOLD = 16
) (
    input  logic              CLK_4M,
    input  logic              nRESET,
    input  logic              ioctl_download,
    input  logic              ioctl_upload,
    input  logic              ioctl_wr,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic [ROM_AW-1:0] dn_addr,
    output logic [7:0]        dn_data,
    output logic              dn_wr,
    input  logic              cpu_ram_req,
    output logic              cpu_wait_n,
    output logic              ram_sel,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    input  logic [7:0]        ram_dout,
    output logic              game_reset_n
);

    nv_state_e         state_q, state_d;
    logic              wait_q, wait_d;
    logic [7:0]        din_q, din_d;
    logic              dn_wr_q, dn_wr_d;
    logic [ROM_AW-1:0] dn_addr_q, dn_addr_d;
    logic [7:0]        dn_data_q, dn_data_d;
    logic              sel_q, sel_d;
    logic              we_q, we_d;
    logic [RAM_AW-1:0] raddr_q, raddr_d;
    logic [7:0]        rdin_q, rdin_d;
    logic              dir_wr_q, dir_wr_d;

    logic rom_active, rom_in_range, nv_wr_stb, nv_rd_stb, nv_in_range;

    assign rom_active   = ioctl_download && (ioctl_index == ROM_INDEX);
    assign rom_in_range = (ioctl_addr[24:ROM_AW] == '0);
    assign nv_wr_stb    = ioctl_download && (ioctl_index == NV_INDEX) && ioctl_wr;
    // Download takes precedence: read strobes only count when no download is running.
    assign nv_rd_stb    = !ioctl_download && ioctl_upload && (ioctl_index == NV_INDEX) && ioctl_rd;
    assign nv_in_range  = (ioctl_addr[24:RAM_AW] == '0);

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        din_d     = din_q;
        dn_wr_d   = 1'b0;
        dn_addr_d = dn_addr_q;
        dn_data_d = dn_data_q;
        sel_d     = sel_q;
        we_d      = 1'b0;
        raddr_d   = raddr_q;
        rdin_d    = rdin_q;
        dir_wr_d  = dir_wr_q;

        if (rom_active && ioctl_wr && rom_in_range) begin
            dn_wr_d   = 1'b1;
            dn_addr_d = ioctl_addr[ROM_AW-1:0];
            dn_data_d = ioctl_dout;
        end

        case (state_q)
            IDLE: begin
                if ((nv_wr_stb || nv_rd_stb) && nv_in_range) begin
                    state_d  = NV_REQ;
                    wait_d   = 1'b1;
                    raddr_d  = ioctl_addr[RAM_AW-1:0];
                    rdin_d   = ioctl_dout;
                    dir_wr_d = nv_wr_stb;
                end else if (nv_rd_stb) begin
                    din_d = 8'hFF;
                end
            end
            NV_REQ: begin
                if (!cpu_ram_req) begin
                    sel_d = 1'b1;
                    if (dir_wr_q) begin
                        state_d = NV_WR;
                        we_d    = 1'b1;
                    end else begin
                        state_d = NV_RD;
                    end
                end
            end
            NV_WR: begin
                state_d = IDLE;
                sel_d   = 1'b0;
                wait_d  = 1'b0;
            end
            NV_RD: begin
                state_d = NV_RDV;
            end
            NV_RDV: begin
                din_d   = ram_dout;
                sel_d   = 1'b0;
                wait_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                sel_d   = 1'b0;
                wait_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK_4M) begin
        if (!nRESET) begin
            state_q   <= IDLE;
            wait_q    <= 1'b0;
            din_q     <= 8'h00;
            dn_wr_q   <= 1'b0;
            dn_addr_q <= '0;
            dn_data_q <= 8'h00;
            sel_q     <= 1'b0;
            we_q      <= 1'b0;
            raddr_q   <= '0;
            rdin_q    <= 8'h00;
            dir_wr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            din_q     <= din_d;
            dn_wr_q   <= dn_wr_d;
            dn_addr_q <= dn_addr_d;
            dn_data_q <= dn_data_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            raddr_q   <= raddr_d;
            rdin_q    <= rdin_d;
            dir_wr_q  <= dir_wr_d;
        end
    end

    dottori_reset_hold #(
        .HOLD (RESET_HOLD)
    ) u_reset_hold (
        .clk_i   (CLK_4M),
        .rst_n_i (nRESET),
        .load_i  (rom_active),
        .done_o  (game_reset_n)
    );

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign dn_wr      = dn_wr_q;
    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign ram_sel    = sel_q;
    assign ram_we     = we_q;
    assign ram_addr   = raddr_q;
    assign ram_din    = rdin_q;
    // Stall the Z80 only when it actually touches RAM while we own the port.
    assign cpu_wait_n = !(sel_q && cpu_ram_req);

endmodule

// File: tb/tb_dottori_ioctl_arbiter.sv
// Directed vector bench for dottori_ioctl_arbiter with a small work RAM model.
module tb_dottori_ioctl_arbiter;

    logic        CLK_4M = 1'b0;
    logic        nRESET = 1'b0;
    logic        ioctl_download = 1'b0, ioctl_upload = 1'b0;
    logic        ioctl_wr = 1'b0, ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0, ioctl_index = '0;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic [13:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        cpu_ram_req = 1'b0;
    logic        cpu_wait_n, ram_sel, ram_we, game_reset_n;
    logic [10:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout = 8'h00;

    dottori_ioctl_arbiter dut (
        .CLK_4M(CLK_4M), .nRESET(nRESET),
        .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
        .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
        .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
        .cpu_ram_req(cpu_ram_req), .cpu_wait_n(cpu_wait_n),
        .ram_sel(ram_sel), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_we(ram_we), .ram_dout(ram_dout), .game_reset_n(game_reset_n)
    );

    always #5 CLK_4M = ~CLK_4M;

    // Work RAM: 1-cycle registered read; location 0x7FF preloaded while in reset.
    logic [7:0] mem [0:2047];
    int we_cnt = 0;
    always @(posedge CLK_4M) begin
        if (!nRESET)
            mem[11'h7FF] <= 8'h81;
        else if (ram_we) begin
            mem[ram_addr] <= ram_din;
            we_cnt <= we_cnt + 1;
        end
        ram_dout <= mem[ram_addr];
    end

    int n_vec = 0;
    int n_bad = 0;

    always @(negedge CLK_4M) begin
        if (nRESET && (ioctl_wr || ioctl_rd) && ioctl_wait) begin
            n_bad++;
            $display("FAIL protocol: strobe while ioctl_wait=%0b", ioctl_wait);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK_4M);
        #1;
    endtask

    typedef struct {
        logic        dl, ul, wr, rd;
        logic [24:0] addr;
        logic [7:0]  dout, idx;
        logic        e_dnwr;
        logic [13:0] e_dnaddr;
        logic [7:0]  e_dndata;
        logic        e_wait, e_sel, e_we, e_grn;
        logic        cd;
        logic [7:0]  e_din;
        logic        cr;
        logic [10:0] e_raddr;
        logic [7:0]  e_rdin;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic dl, ul, wr, rd, input logic [24:0] addr, input logic [7:0] dout, idx,
        input logic e_dnwr, input logic [13:0] e_dnaddr, input logic [7:0] e_dndata,
        input logic e_wait, e_sel, e_we, e_grn,
        input logic cd, input logic [7:0] e_din,
        input logic cr, input logic [10:0] e_raddr, input logic [7:0] e_rdin);
        vec_t v;
        v.dl = dl; v.ul = ul; v.wr = wr; v.rd = rd; v.addr = addr; v.dout = dout; v.idx = idx;
        v.e_dnwr = e_dnwr; v.e_dnaddr = e_dnaddr; v.e_dndata = e_dndata;
        v.e_wait = e_wait; v.e_sel = e_sel; v.e_we = e_we; v.e_grn = e_grn;
        v.cd = cd; v.e_din = e_din; v.cr = cr; v.e_raddr = e_raddr; v.e_rdin = e_rdin;
        return v;
    endfunction

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            ioctl_download = vt[i].dl; ioctl_upload = vt[i].ul;
            ioctl_wr = vt[i].wr; ioctl_rd = vt[i].rd;
            ioctl_addr = vt[i].addr; ioctl_dout = vt[i].dout; ioctl_index = vt[i].idx;
            step();
            ioctl_wr = 1'b0; ioctl_rd = 1'b0;
            chk($sformatf("v%0d.dn_wr", i), dn_wr, vt[i].e_dnwr);
            chk($sformatf("v%0d.dn_addr", i), dn_addr, vt[i].e_dnaddr);
            chk($sformatf("v%0d.dn_data", i), dn_data, vt[i].e_dndata);
            chk($sformatf("v%0d.ioctl_wait", i), ioctl_wait, vt[i].e_wait);
            chk($sformatf("v%0d.ram_sel", i), ram_sel, vt[i].e_sel);
            chk($sformatf("v%0d.ram_we", i), ram_we, vt[i].e_we);
            chk($sformatf("v%0d.game_reset_n", i), game_reset_n, vt[i].e_grn);
            chk($sformatf("v%0d.cpu_wait_n", i), cpu_wait_n, 1'b1);
            if (vt[i].cd) chk($sformatf("v%0d.ioctl_din", i), ioctl_din, vt[i].e_din);
            if (vt[i].cr) begin
                chk($sformatf("v%0d.ram_addr", i), ram_addr, vt[i].e_raddr);
                chk($sformatf("v%0d.ram_din", i), ram_din, vt[i].e_rdin);
            end
        end
    endtask

    initial begin
        // ROM download, index 0 (vectors 0..4)
        vt.push_back(mk(1,0,0,0,25'h0000,8'h00,8'd0, 0,14'h0000,8'h00, 0,0,0,0, 0,8'h00, 0,11'h0,8'h0));
        vt.push_back(mk(1,0,1,0,25'h0123,8'hA5,8'd0, 1,14'h0123,8'hA5, 0,0,0,0, 0,8'h00, 0,11'h0,8'h0));
        vt.push_back(mk(1,0,0,0,25'h0123,8'hA5,8'd0, 0,14'h0123,8'hA5, 0,0,0,0, 0,8'h00, 0,11'h0,8'h0));
        vt.push_back(mk(1,0,1,0,25'h4000,8'h5A,8'd0, 0,14'h0123,8'hA5, 0,0,0,0, 0,8'h00, 0,11'h0,8'h0));
        vt.push_back(mk(1,0,0,0,25'h4000,8'h5A,8'd0, 0,14'h0123,8'hA5, 0,0,0,0, 0,8'h00, 0,11'h0,8'h0));
        // NVRAM load, out-of-range read, foreign index, download+upload (vectors 5..12)
        vt.push_back(mk(1,0,1,0,25'h0010,8'h3C,8'd4, 0,14'h0123,8'hA5, 1,0,0,1, 0,8'h00, 0,11'h0,8'h0));
        vt.push_back(mk(1,0,0,0,25'h0010,8'h3C,8'd4, 0,14'h0123,8'hA5, 1,1,1,1, 0,8'h00, 1,11'h010,8'h3C));
        vt.push_back(mk(1,0,0,0,25'h0010,8'h3C,8'd4, 0,14'h0123,8'hA5, 0,0,0,1, 0,8'h00, 0,11'h0,8'h0));
        vt.push_back(mk(0,1,0,1,25'h0800,8'h00,8'd4, 0,14'h0123,8'hA5, 0,0,0,1, 1,8'hFF, 0,11'h0,8'h0));
        vt.push_back(mk(0,1,0,0,25'h0800,8'h00,8'd4, 0,14'h0123,8'hA5, 0,0,0,1, 1,8'hFF, 0,11'h0,8'h0));
        vt.push_back(mk(1,0,1,0,25'h0005,8'h99,8'd2, 0,14'h0123,8'hA5, 0,0,0,1, 0,8'h00, 0,11'h0,8'h0));
        vt.push_back(mk(1,1,0,1,25'h07FF,8'h00,8'd4, 0,14'h0123,8'hA5, 0,0,0,1, 1,8'hFF, 0,11'h0,8'h0));
        vt.push_back(mk(0,0,0,0,25'h0000,8'h00,8'd0, 0,14'h0123,8'hA5, 0,0,0,1, 1,8'hFF, 0,11'h0,8'h0));

        // Reset: 3 cycles low, then check reset values
        nRESET = 1'b0;
        repeat (3) step();
        chk("rst.ioctl_wait", ioctl_wait, 1'b0);
        chk("rst.ioctl_din", ioctl_din, 8'h00);
        chk("rst.dn_wr", dn_wr, 1'b0);
        chk("rst.dn_addr", dn_addr, 14'h0);
        chk("rst.dn_data", dn_data, 8'h00);
        chk("rst.ram_sel", ram_sel, 1'b0);
        chk("rst.ram_we", ram_we, 1'b0);
        chk("rst.ram_addr", ram_addr, 11'h0);
        chk("rst.ram_din", ram_din, 8'h00);
        chk("rst.cpu_wait_n", cpu_wait_n, 1'b1);
        chk("rst.game_reset_n", game_reset_n, 1'b0);
        nRESET = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk($sformatf("rst_hold.c%0d", i), game_reset_n, (i == 16));
        end

        apply(0, 4);
        ioctl_download = 1'b0; ioctl_index = 8'd0;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk($sformatf("dl_hold.c%0d", i), game_reset_n, (i == 16));
        end
        apply(5, 12);

        // NVRAM save with CPU contention: 5 busy cycles after the strobe
        ioctl_upload = 1'b1; ioctl_index = 8'd4; ioctl_addr = 25'h7FF; ioctl_rd = 1'b1;
        cpu_ram_req = 1'b1;
        step();
        ioctl_rd = 1'b0;
        chk("sv.e0.wait", ioctl_wait, 1'b1);
        chk("sv.e0.sel", ram_sel, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("sv.busy%0d.wait", i), ioctl_wait, 1'b1);
            chk($sformatf("sv.busy%0d.sel", i), ram_sel, 1'b0);
            chk($sformatf("sv.busy%0d.cwn", i), cpu_wait_n, 1'b1);
        end
        cpu_ram_req = 1'b0;
        step();
        chk("sv.rd.wait", ioctl_wait, 1'b1);
        chk("sv.rd.sel", ram_sel, 1'b1);
        chk("sv.rd.addr", ram_addr, 11'h7FF);
        chk("sv.rd.cwn_idle", cpu_wait_n, 1'b1);
        cpu_ram_req = 1'b1;
        #1;
        chk("sv.rd.cwn_stall", cpu_wait_n, 1'b0);
        step();
        chk("sv.rdv.wait", ioctl_wait, 1'b1);
        chk("sv.rdv.sel", ram_sel, 1'b1);
        chk("sv.rdv.cwn", cpu_wait_n, 1'b0);
        chk("sv.rdv.din_old", ioctl_din, 8'hFF);
        cpu_ram_req = 1'b0;
        step();
        chk("sv.done.wait", ioctl_wait, 1'b0);
        chk("sv.done.din", ioctl_din, 8'h81);
        chk("sv.done.sel", ram_sel, 1'b0);
        chk("sv.done.cwn", cpu_wait_n, 1'b1);
        ioctl_upload = 1'b0;

        // Reset while in NV_REQ aborts the write
        ioctl_download = 1'b1; ioctl_index = 8'd4; ioctl_addr = 25'h020; ioctl_dout = 8'h77;
        ioctl_wr = 1'b1; cpu_ram_req = 1'b1;
        step();
        ioctl_wr = 1'b0;
        chk("ab.req.wait", ioctl_wait, 1'b1);
        step();
        chk("ab.busy.wait", ioctl_wait, 1'b1);
        chk("ab.busy.sel", ram_sel, 1'b0);
        nRESET = 1'b0; cpu_ram_req = 1'b0;
        step();
        chk("ab.rst.wait", ioctl_wait, 1'b0);
        chk("ab.rst.sel", ram_sel, 1'b0);
        chk("ab.rst.we", ram_we, 1'b0);
        chk("ab.rst.din", ioctl_din, 8'h00);
        chk("ab.rst.grn", game_reset_n, 1'b0);
        nRESET = 1'b1; ioctl_download = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("ab.post%0d.we", i), ram_we, 1'b0);
            chk($sformatf("ab.post%0d.sel", i), ram_sel, 1'b0);
            chk($sformatf("ab.post%0d.wait", i), ioctl_wait, 1'b0);
        end
        chk("ab.we_count", we_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dottori_ioctl_arbiter.md
Name: dottori_ioctl_arbiter

Overview:
Sits between the MiSTer ioctl interface and the dottori core.
- Routes ROM download writes to the core's dn_* port.
- Shares the core's 2 KB work RAM port between the Z80 and ioctl NVRAM (hiscore) load/save transfers.
- Sequences the game reset around downloads.
- Paces the ioctl master with ioctl_wait.

Parameters:
ROM_INDEX, 8'd0, ioctl_index value selecting ROM download.
NV_INDEX, 8'd4, ioctl_index value selecting NVRAM load/save.
RAM_AW, 11, work RAM address width (2 KB).
RESET_HOLD, 16, CLK_4M cycles game_reset_n stays low after reset release or download end.

Ports:
CLK_4M  in  1  system clock, 4 MHz.
nRESET  in  1  reset: synchronous and active-low.
ioctl_download  in  1  download in progress.
ioctl_upload  in  1  upload in progress.
ioctl_wr  in  1  one-cycle write strobe.
ioctl_rd  in  1  one-cycle read strobe (upload).
ioctl_addr  in  25  byte address.
ioctl_dout  in  8  write data.
ioctl_index  in  8  transfer selector.
ioctl_din  out  8  read data to master.
ioctl_wait  out  1  master must not strobe while high.
dn_addr  out  14  ROM write address to core.
dn_data  out  8  ROM write data.
dn_wr  out  1  ROM write strobe.
cpu_ram_req  in  1  Z80 RAM access active this cycle.
cpu_wait_n  out  1  low = stall Z80 (to core WAIT_n).
ram_sel  out  1  1 = arbiter owns RAM port (core muxes address/data).
ram_addr  out  RAM_AW  arbiter RAM address.
ram_din  out  8  arbiter RAM write data.
ram_we  out  1  arbiter RAM write enable.
ram_dout  in  8  RAM read data, 1-cycle registered latency.
game_reset_n  out  1  active-low reset to dottori core.

Behaviour:
- Reset (nRESET=0 at an edge):
  - FSM to IDLE; ioctl_wait=0, ioctl_din=8'h00, dn_wr=0, dn_addr=0, dn_data=0, ram_sel=0, ram_we=0, ram_addr=0, ram_din=0, cpu_wait_n=1, game_reset_n=0, hold counter loaded with RESET_HOLD.
  - Reset mid-transfer aborts it with no RAM write.
- game_reset_n:
  - Low while ioctl_download=1 and index=ROM_INDEX.
  - After reset or ROM download end, the counter reloads and counts down; game_reset_n rises in the cycle the counter reaches 0, i.e. exactly RESET_HOLD cycles low after release.
  - NVRAM transfers never touch game_reset_n.
- ROM path (download=1, index=ROM_INDEX):
  - ioctl_wr registered one cycle: dn_wr=1 for one cycle, carrying dn_addr=ioctl_addr[13:0] and dn_data=ioctl_dout.
  - ioctl_addr[24:14]≠0 suppresses dn_wr.
  - ioctl_wait stays 0.
- Index decode: strobes with any index other than ROM_INDEX/NV_INDEX are ignored. If download and upload are both high, download wins and ioctl_rd is ignored.
- NVRAM FSM states: IDLE, NV_REQ, NV_WR, NV_RD, NV_RDV.
  - IDLE → NV_REQ on ioctl_wr (download, NV_INDEX) or ioctl_rd (upload, NV_INDEX) with ioctl_addr < 2^RAM_AW. On that edge, capture address/data/direction and set ioctl_wait=1.
  - Out-of-range strobe: no RAM access, ioctl_wait stays 0. On reads, ioctl_din=8'hFF on the next cycle.
  - NV_REQ: the CPU has priority. Stay while cpu_ram_req=1. On the first cycle with cpu_ram_req=0, set ram_sel=1 and go to NV_WR (write) or NV_RD (read).
  - NV_WR: ram_we=1 for exactly one cycle, then → IDLE with ram_sel=0, ram_we=0, ioctl_wait=0. Total ioctl_wait high time = 2 + CPU-busy cycles.
  - NV_RD: address presented → NV_RDV.
  - NV_RDV: ioctl_din<=ram_dout, ram_sel=0, ioctl_wait=0 → IDLE.
  - Whenever ram_sel=1 and cpu_ram_req=1, cpu_wait_n=0 (combinational on cpu_ram_req, registered ownership). Otherwise cpu_wait_n=1.
  - A strobe arriving while ioctl_wait=1 is a protocol violation: it is ignored, and the bench flags it.
- RAM address = captured ioctl_addr[RAM_AW-1:0]. No wrap; out-of-range handling is as above.

Decomposition:
- Package dottori_pkg:
  - FSM state enum (IDLE, NV_REQ, NV_WR, NV_RD, NV_RDV).
  - ROM_INDEX/NV_INDEX default constants.
  - ROM_AW=14.
- Sub-module dottori_reset_hold: the RESET_HOLD down-counter with load/count/done.
- Everything else stays flat.

Test Plan:
- Reset: nRESET low 3 cycles, then high → all outputs at reset values; game_reset_n rises exactly 16 cycles after release.
- ROM download, index 0: wr at addr 0x0123, data 0xA5 → next cycle dn_wr=1, dn_addr=0x0123, dn_data=0xA5. Wr at addr 0x4000 → no dn_wr. game_reset_n is low throughout and rises 16 cycles after download falls.
- NVRAM load, index 4, CPU idle: wr addr 0x010, data 0x3C → ioctl_wait high 2 cycles, ram_we=1 one cycle with ram_addr=0x010, ram_din=0x3C; game_reset_n unaffected.
- NVRAM save with CPU contention: cpu_ram_req held 5 cycles, rd addr 0x7FF with RAM containing 0x81 → ioctl_wait high 5+3 cycles, ram_sel only after cpu_ram_req falls, ioctl_din=0x81 when wait drops; cpu_ram_req during ownership → cpu_wait_n=0.
- Out-of-range NV read at addr 0x800 → ioctl_wait stays 0, ioctl_din=0xFF next cycle, ram_sel never asserts.
- nRESET low while in NV_REQ → next edge: IDLE, ioctl_wait=0, no ram_we pulse; download+upload both high with rd → ignored.
